// File: rtl/mem_block_responder_pkg.sv
// Shared definitions for the block memory responder: FSM encoding, bus widths
// and default latency.
package mem_block_responder_pkg;

    localparam int ADDR_W      = 28;
    localparam int BLOCK_W     = 128;
    localparam int LATENCY_DEF = 4;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_block_responder_block_ram.sv
// Unreset block storage: one synchronous write port, one combinational read port.
module block_ram
    import mem_block_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [BLOCK_W-1:0]    wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [BLOCK_W-1:0]    rdata
);

    logic [BLOCK_W-1:0] mem_r [2**DEPTH_LOG2];

    // Synchronous write; contents are masked by the owner's valid bits after reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/mem_block_responder.sv
// Fixed-latency block memory responder: accepts one read/write request, answers
// with a one-cycle registered mem_ready pulse LATENCY cycles after request onset.
module mem_block_responder
    import mem_block_responder_pkg::*;
#(
    parameter int LATENCY    = LATENCY_DEF,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [ADDR_W-1:0]  mem_addr,
    input  logic [BLOCK_W-1:0] mem_wdata,
    output logic [BLOCK_W-1:0] mem_rdata,
    output logic               mem_ready,
    output logic               proto_err
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_t                  state_r, state_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s;
    logic                    accept_s, enter_resp_s, err_s;
    logic [DEPTH_LOG2-1:0]   addr_r;
    logic [BLOCK_W-1:0]      wdata_r;
    logic                    is_write_r;
    logic [2**DEPTH_LOG2-1:0] valid_r;
    logic [BLOCK_W-1:0]      mem_rdata_r;
    logic                    mem_ready_r;
    logic                    proto_err_r;

    logic                    op_write_s;
    logic [DEPTH_LOG2-1:0]   op_addr_s;
    logic [BLOCK_W-1:0]      op_wdata_s;
    logic [BLOCK_W-1:0]      ram_rdata_s;
    logic                    addr_unused_s;

    assign addr_unused_s = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

    // With LATENCY=1 the operation completes on the accept edge, so the live
    // inputs stand in for the not-yet-sampled registers while in IDLE.
    assign op_write_s = (state_r == ST_IDLE) ? mem_write : is_write_r;
    assign op_addr_s  = (state_r == ST_IDLE) ? mem_addr[DEPTH_LOG2-1:0] : addr_r;
    assign op_wdata_s = (state_r == ST_IDLE) ? mem_wdata : wdata_r;

    block_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_block_ram (
        .clk   (clk),
        .we    (enter_resp_s && op_write_s),
        .waddr (op_addr_s),
        .wdata (op_wdata_s),
        .raddr (op_addr_s),
        .rdata (ram_rdata_s)
    );

    // Next-state, counter and protocol-error decode.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        accept_s     = 1'b0;
        enter_resp_s = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    accept_s = 1'b1;
                    err_s    = mem_read && mem_write;
                    if (LATENCY == 1) begin
                        state_s      = ST_RESP;
                        enter_resp_s = 1'b1;
                        cnt_s        = '0;
                    end else begin
                        state_s = ST_BUSY;
                        cnt_s   = LAT_M1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                err_s = !(mem_read || mem_write);
                if (cnt_r <= 4'd1) begin
                    state_s      = ST_RESP;
                    enter_resp_s = 1'b1;
                    cnt_s        = '0;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // State, sampled request, valid bits and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            addr_r      <= '0;
            wdata_r     <= '0;
            is_write_r  <= 1'b0;
            valid_r     <= '0;
            mem_rdata_r <= '0;
            mem_ready_r <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            mem_ready_r <= enter_resp_s;
            if (accept_s) begin
                addr_r     <= mem_addr[DEPTH_LOG2-1:0];
                wdata_r    <= mem_wdata;
                is_write_r <= mem_write;
            end
            if (err_s) begin
                proto_err_r <= 1'b1;
            end
            if (enter_resp_s) begin
                if (op_write_s) begin
                    valid_r[op_addr_s] <= 1'b1;
                end else begin
                    mem_rdata_r <= valid_r[op_addr_s] ? ram_rdata_s : '0;
                end
            end
        end
    end

    assign mem_rdata = mem_rdata_r;
    assign mem_ready = mem_ready_r;
    assign proto_err = proto_err_r;

endmodule

// File: tb/tb_mem_block_responder.sv
// Directed bench for mem_block_responder: a LATENCY=4 instance driven from a
// vector table plus corner sequences, and a LATENCY=1 instance for back-to-back.
module tb_mem_block_responder;

    localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D2 = 128'hDEADBEEF00000000CAFEF00D11111111;
    localparam logic [127:0] D3 = 128'h00000000000000000000000000000001;
    localparam logic [127:0] D4 = 128'hFFFFFFFF00000000FFFFFFFF00000000;
    localparam logic [127:0] D5 = 128'h0F0F0F0F1E1E1E1E2D2D2D2D3C3C3C3C;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ready, proto_err;

    logic         b_read, b_write;
    logic [27:0]  b_addr;
    logic [127:0] b_wdata, b_rdata;
    logic         b_ready, b_err;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [127:0] exp_rdata;
        logic         exp_err;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    mem_block_responder #(.LATENCY(4), .DEPTH_LOG2(6)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .proto_err(proto_err)
    );

    mem_block_responder #(.LATENCY(1), .DEPTH_LOG2(6)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .mem_read(b_read), .mem_write(b_write),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata),
        .mem_ready(b_ready), .proto_err(b_err)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: no mem_ready within cycle budget", name);
    endtask

    // One request on the LATENCY=4 instance; inputs are scrambled during BUSY.
    task automatic run_op(input logic rd, input logic wr, input logic [27:0] addr,
                          input logic [127:0] wd, input int drop_after,
                          output int lat, output logic [127:0] rdv, output logic errv);
        mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = wd;
        lat = -1; rdv = '0; errv = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                lat = c; rdv = mem_rdata; errv = proto_err;
                break;
            end
            if (c == 1) begin
                mem_addr = ~addr; mem_wdata = ~wd;
            end
            if (c == drop_after) begin
                mem_read = 1'b0; mem_write = 1'b0;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        if (lat < 0) begin
            timeout("run_op");
        end else begin
            @(posedge clk); #1;
            check("ready_width", 128'(mem_ready), 128'd0);
        end
    endtask

    initial begin
        int lat, pulses, c2, issued, raise_cyc, last_pulse;
        logic [127:0] rdv;
        logic errv;

        vecs[0] = '{1'b0, 1'b1, 28'h0000005, D1, 128'd0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 28'h0000005, 128'd0, D1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 28'h0000009, 128'd0, 128'd0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 28'h0000045, D2, 128'd0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 28'h0000005, 128'd0, D2, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 28'h0000010, D3, D2, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 28'h0000010, 128'd0, D3, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 28'h0000020, D4, D3, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 28'h0000020, 128'd0, D4, 1'b1};

        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
        b_read = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 128'(mem_ready), 128'd0);
        check("reset_rdata", mem_rdata, 128'd0);
        check("reset_err", 128'(proto_err), 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, lat, rdv, errv);
            check($sformatf("vec%0d_latency", i), 128'(lat), 128'd4);
            check($sformatf("vec%0d_rdata", i), rdv, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 128'(errv), 128'(vecs[i].exp_err));
        end

        // Write 0x45, then hold a read of 0x5 through RESP: re-accepted after RESP.
        mem_write = 1'b1; mem_addr = 28'h0000045; mem_wdata = D5;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (mem_ready) begin lat = c; break; end
        end
        check("alias_wr_latency", 128'(lat), 128'd4);
        mem_write = 1'b0; mem_read = 1'b1; mem_addr = 28'h0000005;
        c2 = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (mem_ready) begin c2 = c; rdv = mem_rdata; break; end
        end
        mem_read = 1'b0;
        check("alias_rd_gap", 128'(c2), 128'd5);
        check("alias_rd_data", rdv, D5);
        @(posedge clk); #1;

        // Reset two cycles into a write: nothing completes, nothing is stored.
        mem_write = 1'b1; mem_addr = 28'h0000003; mem_wdata = '1;
        pulses = 0;
        repeat (2) begin @(posedge clk); #1; pulses += int'(mem_ready); end
        rst_n = 1'b0; mem_write = 1'b0;
        #1;
        check("midrst_rdata", mem_rdata, 128'd0);
        check("midrst_err", 128'(proto_err), 128'd0);
        repeat (2) begin @(posedge clk); #1; pulses += int'(mem_ready); end
        rst_n = 1'b1;
        repeat (6) begin @(posedge clk); #1; pulses += int'(mem_ready); end
        check("midrst_pulses", 128'(pulses), 128'd0);
        run_op(1'b1, 1'b0, 28'h0000003, 128'd0, 0, lat, rdv, errv);
        check("midrst_rd3_latency", 128'(lat), 128'd4);
        check("midrst_rd3_data", rdv, 128'd0);
        run_op(1'b1, 1'b0, 28'h0000005, 128'd0, 0, lat, rdv, errv);
        check("midrst_rd5_data", rdv, 128'd0);
        check("midrst_rd5_err", 128'(errv), 128'd0);

        // Request dropped mid-BUSY: write still completes, error latched.
        run_op(1'b0, 1'b1, 28'h0000007, D1, 2, lat, rdv, errv);
        check("drop_latency", 128'(lat), 128'd4);
        check("drop_err", 128'(errv), 128'd1);
        run_op(1'b1, 1'b0, 28'h0000007, 128'd0, 0, lat, rdv, errv);
        check("drop_rd_data", rdv, D1);
        check("drop_err_sticky", 128'(errv), 128'd1);

        // LATENCY=1 instance: one write then 10 back-to-back reads.
        b_write = 1'b1; b_addr = 28'h0000002; b_wdata = D2;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (b_ready) begin lat = c; break; end
        end
        b_write = 1'b0;
        check("l1_wr_latency", 128'(lat), 128'd1);
        @(posedge clk); #1;
        b_read = 1'b1; issued = 1; raise_cyc = 0; pulses = 0; last_pulse = -1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk); #1;
            if (b_ready) begin
                pulses++;
                check("l1_rd_latency", 128'(cyc - raise_cyc), 128'd1);
                check("l1_rd_data", b_rdata, D2);
                if (last_pulse >= 0) begin
                    check("l1_pulse_gap", 128'(cyc - last_pulse), 128'd2);
                end
                last_pulse = cyc;
                b_read = 1'b0;
            end else if (issued < 10) begin
                b_read = 1'b1; issued++; raise_cyc = cyc;
            end
        end
        b_read = 1'b0;
        check("l1_pulse_count", 128'(pulses), 128'd10);
        check("l1_err", 128'(b_err), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_block_responder.md
MEM_BLOCK_RESPONDER -- requirements
Module: mem_block_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from the first request cycle to the mem_ready cycle; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_LOG2, default 6: log2 of the number of 128-bit blocks stored.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port mem_read, input, 1: block read request, held high until the requester sees mem_ready.
REQ-006 SHALL have port mem_write, input, 1: block write request, held high until the requester sees mem_ready.
REQ-007 SHALL have port mem_addr, input, 28: block address; only bits [DEPTH_LOG2-1:0] index storage, upper bits ignored (aliasing).
REQ-008 SHALL have port mem_wdata, input, 128: write block data.
REQ-009 SHALL have port mem_rdata, output, 128: read block data, registered.
REQ-010 SHALL have port mem_ready, output, 1: one-cycle completion pulse, registered.
REQ-011 SHALL have port proto_err, output, 1: sticky protocol-violation flag, registered.

Function
REQ-012 SHALL implement an FSM with states IDLE, BUSY and RESP.
REQ-013 SHALL, in IDLE with mem_read or mem_write high, accept the request: sample mem_addr, mem_wdata and the operation; load the latency counter with LATENCY-1.
REQ-014 SHALL enter RESP directly on accept when LATENCY=1, otherwise enter BUSY.
REQ-015 SHALL decrement the counter each BUSY cycle and go to RESP on the edge where it reaches 0.
REQ-016 SHALL drive mem_ready=1 only in RESP, exactly one cycle, then return to IDLE.
REQ-017 SHALL make mem_ready rise LATENCY cycles after the first request cycle.
REQ-018 SHALL drive mem_ready from a flop only, with no combinational path from inputs; the requester drops its request combinationally on mem_ready.
REQ-019 SHALL ignore mem_read/mem_write during RESP; a request that is still high is accepted in the following IDLE cycle.
REQ-020 SHALL, for a write, commit the sampled data to storage and set the block's valid bit on the edge entering RESP.
REQ-021 SHALL, for a write, leave mem_rdata unchanged.
REQ-022 SHALL, for a read, load mem_rdata on the edge entering RESP with the stored block, or 128'd0 if the block's valid bit is clear.
REQ-023 SHALL hold mem_rdata at its value outside a read completion.
REQ-024 SHALL use the sampled address and data only; input changes during BUSY are ignored.
REQ-025 SHALL, when mem_read and mem_write are both high at accept, perform the write, ignore the read and set proto_err.
REQ-026 SHALL, when the request drops during BUSY, still complete the sampled operation and set proto_err.
REQ-027 SHALL make a read that follows a write to the same block, back-to-back, return the new data.

Reset
REQ-028 SHALL, on rst_n low at any time, immediately force state=IDLE, counter=0, mem_ready=0, mem_rdata=0, proto_err=0 and all valid bits=0.
REQ-029 SHALL discard any in-flight operation on reset; an uncommitted write is not written.
REQ-030 SHALL leave storage data unreset; the cleared valid bits mask it.

Structure
REQ-031 SHALL define in a shared package: the FSM state encoding, ADDR_W=28, BLOCK_W=128 and the default LATENCY.
REQ-032 SHALL instantiate one sub-module, block_ram: 2^DEPTH_LOG2 x 128 storage, one synchronous write port, one combinational read port, no reset.
REQ-033 SHALL keep the FSM, counter, valid bits and output registers in mem_block_responder.

Verification
REQ-034 SHALL cover: reset; write addr 0x0000005 data 0x0123..CDEF with LATENCY=4 -> mem_ready pulses once, 4 cycles after request onset; proto_err=0.
REQ-035 SHALL cover: read addr 0x0000005 after that write -> mem_rdata=0x0123..CDEF in the mem_ready cycle; read of unwritten addr 0x0000009 -> 128'd0.
REQ-036 SHALL cover: write-back then fill, i.e. write 0x0000045 then read 0x0000005 with the request held through RESP -> second accept occurs the cycle after RESP; with DEPTH_LOG2=6 the read returns the 0x0000045 data (alias).
REQ-037 SHALL cover: LATENCY=1 -> mem_ready in the cycle after each request onset; 10 back-to-back reads give 10 pulses, one every 2 cycles.
REQ-038 SHALL cover: mem_read and mem_write both high -> write performed, proto_err=1 and stays 1; request dropped mid-BUSY -> operation completes and proto_err=1.
REQ-039 SHALL cover: rst_n low 2 cycles into a write of 0xFFFF..FFFF to addr 0x3 -> mem_ready never pulses; a subsequent read of 0x3 returns 128'd0.
